mem_arbiter: RTL and testbench

Shares the single multicycle main memory between the instruction-cache and data-cache miss handlers. Arbitrates requests and sequences 8-word line fills as pipelined single-word reads. Executes single-word write-through stores. Routes returning words to the requesting side. Sits between the two cache controllers and the main memory model, below the CPU pipeline.

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-side, memory-side and fill-return signals of mem_arbiter.
// master is the arbiter's view; slave is the view of the caches and memory around it.
interface mem_arbiter_if #(
  parameter int LINE_WORDS = 8
);
  localparam int IDX_W = $clog2(LINE_WORDS);

  logic             i_req;
  logic [15:0]      i_addr;
  logic             d_req;
  logic             d_wr;
  logic [15:0]      d_addr;
  logic [15:0]      d_wdata;
  logic             mem_en;
  logic             mem_wr;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata;
  logic             mem_valid;
  logic             fill_valid;
  logic [15:0]      fill_data;
  logic [IDX_W-1:0] fill_idx;
  logic             fill_dst;
  logic             i_done;
  logic             d_done;
  logic             busy;

  modport master (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output fill_valid, fill_data, fill_idx, fill_dst, i_done, d_done, busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  fill_valid, fill_data, fill_idx, fill_dst, i_done, d_done, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares main memory between I/D miss handlers: line fills and write-through stores.
// Define ARB_RR_EN for round-robin arbitration; otherwise the D-side wins every tie.
module mem_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int MEM_LAT    = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.master bus
);
  localparam int               IDX_W     = $clog2(LINE_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINE_WORDS - 1);
  localparam logic [15:0]      BASE_MASK = ~16'(2 * LINE_WORDS - 1);

  // Read returns are counted, never timed, so MEM_LAT only has to be sane.
  if ((LINE_WORDS & (LINE_WORDS - 1)) != 0 || LINE_WORDS < 2 || LINE_WORDS > 16 || MEM_LAT < 1)
  begin : gBadParams
    $error("mem_arbiter: unsupported LINE_WORDS or MEM_LAT");
  end

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t           state;
  logic [IDX_W-1:0] issueCnt;
  logic [IDX_W-1:0] recvCnt;
  logic             side;
  logic             memEn;
  logic             memWr;
  logic [15:0]      memAddr;
  logic [15:0]      memWdata;
  logic             writeDone;
  logic             grantD;
  logic             lastBeat;

`ifdef ARB_RR_EN
  logic lastD;
  assign grantD = bus.d_req & (~bus.i_req | ~lastD);
`else
  assign grantD = bus.d_req;
`endif

  assign lastBeat = (state == FILL) && bus.mem_valid && (recvCnt == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      issueCnt  <= '0;
      recvCnt   <= '0;
      side      <= 1'b0;
      memEn     <= 1'b0;
      memWr     <= 1'b0;
      memAddr   <= 16'h0;
      memWdata  <= 16'h0;
      writeDone <= 1'b0;
`ifdef ARB_RR_EN
      lastD     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            side     <= grantD;
            issueCnt <= '0;
            recvCnt  <= '0;
`ifdef ARB_RR_EN
            lastD    <= grantD;
`endif
            if (grantD && bus.d_wr) begin
              state     <= WRITE;
              memEn     <= 1'b1;
              memWr     <= 1'b1;
              memAddr   <= bus.d_addr;
              memWdata  <= bus.d_wdata;
              writeDone <= 1'b1;
            end else begin
              state    <= FILL;
              memEn    <= 1'b1;
              memWr    <= 1'b0;
              memAddr  <= (grantD ? bus.d_addr : bus.i_addr) & BASE_MASK;
              memWdata <= 16'h0;
            end
          end
        end
        FILL: begin
          if (memEn) begin
            if (issueCnt == LAST_IDX) begin
              memEn   <= 1'b0;
              memAddr <= 16'h0;
            end else begin
              issueCnt <= issueCnt + 1'b1;
              memAddr  <= memAddr + 16'd2;
            end
          end
          // The done pulse itself is combinational on the final beat.
          if (bus.mem_valid) begin
            if (recvCnt == LAST_IDX) begin
              state    <= IDLE;
              recvCnt  <= '0;
              issueCnt <= '0;
              memEn    <= 1'b0;
              memAddr  <= 16'h0;
            end else begin
              recvCnt <= recvCnt + 1'b1;
            end
          end
        end
        WRITE: begin
          state     <= IDLE;
          memEn     <= 1'b0;
          memWr     <= 1'b0;
          memAddr   <= 16'h0;
          memWdata  <= 16'h0;
          writeDone <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en     = memEn;
  assign bus.mem_wr     = memWr;
  assign bus.mem_addr   = memAddr;
  assign bus.mem_wdata  = memWdata;
  assign bus.fill_valid = (state == FILL) && bus.mem_valid;
  assign bus.fill_data  = bus.mem_rdata;
  assign bus.fill_idx   = recvCnt;
  assign bus.fill_dst   = side;
  assign bus.i_done     = lastBeat & ~side;
  assign bus.d_done     = (lastBeat & side) | writeDone;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a timeline reference model.
module tb_mem_arbiter;
  localparam int          LW    = 8;
  localparam int          LAT   = 4;
  localparam logic [15:0] ALIGN = 16'(2 * LW - 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.LINE_WORDS(LW)) bus();
  mem_arbiter #(.LINE_WORDS(LW), .MEM_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {int cyc; logic wr; logic [15:0] addr; logic [15:0] wdata;} mem_rec_t;
  typedef struct {int cyc; logic dst; int idx; logic [15:0] data;} fill_rec_t;
  typedef struct {int cyc; logic side;} done_rec_t;
  typedef struct {int due; logic [15:0] addr;} pend_t;

  mem_rec_t  expMem[$];
  fill_rec_t expFill[$];
  done_rec_t expDone[$];
  pend_t     pend[$];
  bit        modelLastD = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: every accepted read returns addr^A5A5 exactly LAT cycles later.
  initial begin
    pend_t p;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_valid = 1'b0;
      bus.mem_rdata = 16'($urandom);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        bus.mem_valid = 1'b1;
        bus.mem_rdata = p.addr ^ 16'hA5A5;
      end
      if (bus.mem_en && !bus.mem_wr) pend.push_back(pend_t'{cyc + LAT, bus.mem_addr});
    end
  end

  always @(negedge clk) begin
    mem_rec_t  m;
    fill_rec_t f;
    done_rec_t d;
    if (bus.mem_en) begin
      if (expMem.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_unexpected: access addr %0h wr %0b at cycle %0d, none required", bus.mem_addr, bus.mem_wr, cyc);
      end else begin
        m = expMem.pop_front();
        chk("mem_cycle", cyc, m.cyc);
        chk("mem_wr", bus.mem_wr, m.wr);
        chk("mem_addr", bus.mem_addr, m.addr);
        chk("mem_wdata", bus.mem_wdata, m.wdata);
      end
    end else begin
      chk("idle_mem_wr", bus.mem_wr, 0);
      chk("idle_mem_addr", bus.mem_addr, 0);
      chk("idle_mem_wdata", bus.mem_wdata, 0);
    end
    if (bus.fill_valid) begin
      if (expFill.size() == 0) begin
        checks++; errors++;
        $display("FAIL fill_unexpected: fill_valid idx %0d at cycle %0d, none required", bus.fill_idx, cyc);
      end else begin
        f = expFill.pop_front();
        chk("fill_cycle", cyc, f.cyc);
        chk("fill_dst", bus.fill_dst, f.dst);
        chk("fill_idx", bus.fill_idx, f.idx);
        chk("fill_data", bus.fill_data, f.data);
      end
    end
    if (bus.i_done || bus.d_done) begin
      chk("done_both", {bus.i_done, bus.d_done} == 2'b11, 0);
      if (expDone.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: i_done %0b d_done %0b at cycle %0d, none required", bus.i_done, bus.d_done, cyc);
      end else begin
        d = expDone.pop_front();
        chk("done_cycle", cyc, d.cyc);
        chk("done_side", bus.d_done, d.side);
      end
    end
  end

  // Timeline model: each held request is served in grant order; a fill sampled at t
  // reads at t+1..t+LW, returns word k at t+1+k+LAT, finishes at t+LW+LAT, idles one cycle.
  task automatic plan(input int t0, input bit iOn, input int iRep, input logic [15:0] iA,
                      input bit dOn, input bit dW, input int dRep, input logic [15:0] dA,
                      input logic [15:0] dWd);
    int          t;
    int          remI;
    int          remD;
    bit          winD;
    logic [15:0] base;
    logic [15:0] a;
    t    = t0;
    remI = iOn ? iRep : 0;
    remD = dOn ? dRep : 0;
    while (remI + remD > 0) begin
      if (remI > 0 && remD > 0) begin
`ifdef ARB_RR_EN
        winD = !modelLastD;
`else
        winD = 1'b1;
`endif
      end else begin
        winD = (remD > 0);
      end
      modelLastD = winD;
      if (winD && dW) begin
        expMem.push_back(mem_rec_t'{t + 1, 1'b1, dA, dWd});
        expDone.push_back(done_rec_t'{t + 1, 1'b1});
        t += 2;
      end else begin
        base = (winD ? dA : iA) & ~ALIGN;
        for (int k = 0; k < LW; k++) begin
          a = base + 16'(2 * k);
          expMem.push_back(mem_rec_t'{t + 1 + k, 1'b0, a, 16'h0});
          expFill.push_back(fill_rec_t'{t + 1 + k + LAT, winD, k, a ^ 16'hA5A5});
        end
        expDone.push_back(done_rec_t'{t + LW + LAT, winD});
        t += LW + LAT + 1;
      end
      if (winD) remD--; else remI--;
    end
  endtask

  task automatic drain_checks();
    chk("drain_mem", expMem.size(), 0);
    chk("drain_fill", expFill.size(), 0);
    chk("drain_done", expDone.size(), 0);
    chk("drain_busy", bus.busy, 0);
  endtask

  task automatic run(input bit iOn, input int iRep, input logic [15:0] iA,
                     input bit dOn, input bit dW, input int dRep, input logic [15:0] dA,
                     input logic [15:0] dWd);
    int doneI = 0;
    int doneD = 0;
    int n = 0;
    @(negedge clk);
    plan(cyc, iOn, iRep, iA, dOn, dW, dRep, dA, dWd);
    bus.i_req = iOn;  bus.i_addr = iA;
    bus.d_req = dOn;  bus.d_wr = dW;  bus.d_addr = dA;  bus.d_wdata = dWd;
    while ((bus.i_req || bus.d_req) && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.i_done) begin doneI++; if (doneI >= iRep) bus.i_req = 1'b0; end
      if (bus.d_done) begin doneD++; if (doneD >= dRep) bus.d_req = 1'b0; end
    end
    if (bus.i_req || bus.d_req) begin
      checks++; errors++;
      $display("FAIL run_timeout: dones i=%0d d=%0d after %0d cycles, required i=%0d d=%0d", doneI, doneD, n, iRep, dRep);
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
    end
    repeat (3) @(negedge clk);
    drain_checks();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_en"}, bus.mem_en, 0);
    chk({tag, "_mem_wr"}, bus.mem_wr, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_fill_valid"}, bus.fill_valid, 0);
    chk({tag, "_fill_idx"}, bus.fill_idx, 0);
    chk({tag, "_fill_dst"}, bus.fill_dst, 0);
    chk({tag, "_i_done"}, bus.i_done, 0);
    chk({tag, "_d_done"}, bus.d_done, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic reset_mid_fill();
    int n = 0;
    @(negedge clk);
    plan(cyc, 1'b1, 1, 16'h4450, 1'b0, 1'b0, 0, 16'h0, 16'h0);
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h4450;
    while (!(bus.fill_valid && bus.fill_idx == 3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_word3", n < 100, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus.i_req = 1'b0;
    expMem.delete();
    expFill.delete();
    expDone.delete();
    modelLastD = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    drain_checks();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.i_req = 1'b0;  bus.i_addr = 16'h0;
    bus.d_req = 1'b0;  bus.d_wr = 1'b0;  bus.d_addr = 16'h0;  bus.d_wdata = 16'h0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    run(1'b1, 1, 16'h1236, 1'b0, 1'b0, 0, 16'h0, 16'h0);
    run(1'b0, 0, 16'h0, 1'b1, 1'b1, 1, 16'h2003, 16'hBEEF);
    run(1'b1, 2, 16'h0104, 1'b1, 1'b0, 2, 16'h3308, 16'h0);
    run(1'b1, 2, 16'h5558, 1'b0, 1'b0, 0, 16'h0, 16'h0);
    reset_mid_fill();

    for (int s = 0; s < 24; s++) begin
      bit iOn;
      bit dOn;
      iOn = 1'($urandom_range(0, 1));
      dOn = iOn ? 1'($urandom_range(0, 1)) : 1'b1;
      run(iOn, int'($urandom_range(1, 2)), 16'($urandom),
          dOn, 1'($urandom_range(0, 1)), int'($urandom_range(1, 2)), 16'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
